// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence writer.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED0 = 3'd1,
        ST_SEED1 = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } fib_state_e;

    localparam int FIB_SEED = 1;

endpackage : fib_pkg

// File: rtl/fib_adder.sv
// Term adder with carry-out; build option FIB_SAT_EN clamps an overflowing
// sum to all-ones, otherwise the sum wraps modulo 2^DATA_W.
module fib_adder #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_carry
);

    logic [DATA_W:0]   w_full;
    logic [DATA_W-1:0] w_raw;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign w_raw   = w_full[DATA_W-1:0];
    assign o_carry = w_full[DATA_W];

`ifdef FIB_SAT_EN
    assign o_sum = o_carry ? {DATA_W{1'b1}} : w_raw;
`else
    assign o_sum = w_raw;
`endif

endmodule : fib_adder

// File: rtl/fib_seq_fsm.sv
// Writes NUM_TERMS Fibonacci terms to consecutive addresses from BASE_ADDR
// over a ready/valid-style write port. FIB_SAT_EN selects saturating terms.
module fib_seq_fsm
    import fib_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int NUM_TERMS = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TERMS - 1);
    localparam logic [DATA_W-1:0] SEED     = DATA_W'(FIB_SEED);

    fib_state_e        r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_prev;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;

    logic              w_accept;
    logic [DATA_W-1:0] w_sum;
    logic              w_carry;

    assign w_accept = r_we & mem_ready;

    // r_wdata always holds the term on the bus, so prev + current is the next term.
    fib_adder #(
        .DATA_W(DATA_W)
    ) u_adder (
        .i_a    (r_prev),
        .i_b    (r_wdata),
        .o_sum  (w_sum),
        .o_carry(w_carry)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= BASE;
            r_wdata <= '0;
            r_prev  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SEED0;
                        r_we    <= 1'b1;
                        r_addr  <= BASE;
                        r_wdata <= SEED;
                        r_prev  <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_SEED0: begin
                    if (w_accept) begin
                        r_state <= ST_SEED1;
                        r_prev  <= r_wdata;
                        r_wdata <= SEED;
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_idx   <= r_idx + ADDR_W'(1);
                    end
                end
                ST_SEED1, ST_ADD: begin
                    // The last-index test also covers NUM_TERMS=2, leaving from SEED1.
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_we    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_addr  <= BASE;
                            r_wdata <= '0;
                            r_prev  <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_state <= ST_ADD;
                            r_prev  <= r_wdata;
                            r_wdata <= w_sum;
                            r_ovf   <= r_ovf | w_carry;
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_idx   <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_ovf;

endmodule : fib_seq_fsm

// File: tb/tb_fib_seq_fsm.sv
// Directed bench for fib_seq_fsm: three configurations, per-instance write scoreboards.
module tb_fib_seq_fsm;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // dut0: defaults
    logic        s0_start, s0_ready, s0_we, s0_busy, s0_done, s0_ovf;
    logic [14:0] s0_addr;
    logic [15:0] s0_wdata;
    // dut1: 8-bit terms, 14 terms
    logic        s1_start, s1_ready, s1_we, s1_busy, s1_done, s1_ovf;
    logic [14:0] s1_addr;
    logic [7:0]  s1_wdata;
    // dut2: base near top of address space, 4 terms
    logic        s2_start, s2_ready, s2_we, s2_busy, s2_done, s2_ovf;
    logic [14:0] s2_addr;
    logic [15:0] s2_wdata;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    fib_seq_fsm u_dut0 (
        .clk(clk), .clr_n(clr_n), .start(s0_start), .mem_ready(s0_ready),
        .mem_we(s0_we), .mem_addr(s0_addr), .mem_wdata(s0_wdata),
        .busy(s0_busy), .done(s0_done), .overflow(s0_ovf)
    );

    fib_seq_fsm #(.DATA_W(8), .ADDR_W(15), .NUM_TERMS(14), .BASE_ADDR(0)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .start(s1_start), .mem_ready(s1_ready),
        .mem_we(s1_we), .mem_addr(s1_addr), .mem_wdata(s1_wdata),
        .busy(s1_busy), .done(s1_done), .overflow(s1_ovf)
    );

    fib_seq_fsm #(.DATA_W(16), .ADDR_W(15), .NUM_TERMS(4), .BASE_ADDR(32766)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .start(s2_start), .mem_ready(s2_ready),
        .mem_we(s2_we), .mem_addr(s2_addr), .mem_wdata(s2_wdata),
        .busy(s2_busy), .done(s2_done), .overflow(s2_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] fib16(input int i);
        logic [15:0] a, b, t;
        a = 16'd1;
        b = 16'd1;
        for (int k = 2; k <= i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic logic [7:0] fib8(input int i);
        logic [7:0] a, b, t;
        logic [8:0] s;
        a = 8'd1;
        b = 8'd1;
        for (int k = 2; k <= i; k++) begin
            s = {1'b0, a} + {1'b0, b};
`ifdef FIB_SAT_EN
            t = s[8] ? 8'hFF : s[7:0];
`else
            t = s[7:0];
`endif
            a = b;
            b = t;
        end
        return b;
    endfunction

    task automatic push_run0(input int n);
        for (int i = 0; i < n; i++) q0.push_back({1'b0, 15'(i), fib16(i)});
    endtask

    // Scoreboard monitors: a write handshake seen at negedge is accepted at the next posedge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (clr_n && s0_we && s0_ready) begin
            chk("w0_pending", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("w0_addr", 32'(s0_addr), 32'(e[30:16]));
                chk("w0_data", 32'(s0_wdata), 32'(e[15:0]));
            end
        end
        if (clr_n && s1_we && s1_ready) begin
            chk("w1_pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("w1_addr", 32'(s1_addr), 32'(e[30:16]));
                chk("w1_data", 32'(s1_wdata), 32'(e[7:0]));
            end
        end
        if (clr_n && s2_we && s2_ready) begin
            chk("w2_pending", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("w2_addr", 32'(s2_addr), 32'(e[30:16]));
                chk("w2_data", 32'(s2_wdata), 32'(e[15:0]));
            end
        end
    end

    initial begin
        int d0, d1, d2, nd0, c;
        logic [7:0] t13;
        s0_start = 0; s1_start = 0; s2_start = 0;
        s0_ready = 1; s1_ready = 1; s2_ready = 1;
        repeat (2) tick;

        // Reset values
        chk("rst_we", 32'(s0_we), 32'd0);
        chk("rst_busy", 32'(s0_busy), 32'd0);
        chk("rst_done", 32'(s0_done), 32'd0);
        chk("rst_ovf", 32'(s0_ovf), 32'd0);
        chk("rst_addr", 32'(s0_addr), 32'd0);
        chk("rst_wdata", 32'(s0_wdata), 32'd0);
        chk("rst_addr2", 32'(s2_addr), 32'd32766);
        clr_n = 1;
        tick;

        // Full runs on all three instances
        push_run0(16);
        for (int i = 0; i < 14; i++) q1.push_back({1'b0, 15'(i), 8'h00, fib8(i)});
        for (int i = 0; i < 4; i++) q2.push_back({1'b0, 15'(32766 + i), fib16(i)});
        t13 = fib8(13);
`ifdef FIB_SAT_EN
        chk("model_t13", 32'(t13), 32'd255);
`else
        chk("model_t13", 32'(t13), 32'd121);
`endif
        s0_start = 1; s1_start = 1; s2_start = 1;
        d0 = 0; d1 = 0; d2 = 0; nd0 = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            s0_start = 0; s1_start = 0; s2_start = 0;
            if (k == 1) begin
                chk("first_busy", 32'(s0_busy), 32'd1);
                chk("first_we", 32'(s0_we), 32'd1);
                chk("first_addr", 32'(s0_addr), 32'd0);
                chk("first_data", 32'(s0_wdata), 32'd1);
            end
            if (k == 13) chk("ovf1_before", 32'(s1_ovf), 32'd0);
            if (k == 14) begin
                chk("ovf1_set", 32'(s1_ovf), 32'd1);
                chk("t13_data", 32'(s1_wdata), 32'(t13));
            end
            if (k == 17) chk("busy_off_done", 32'(s0_busy), 32'd0);
            if (s0_done) begin nd0++; if (d0 == 0) d0 = k; end
            if (s1_done && d1 == 0) d1 = k;
            if (s2_done && d2 == 0) d2 = k;
        end
        chk("lat0", 32'(d0), 32'd17);
        chk("lat1", 32'(d1), 32'd15);
        chk("lat2", 32'(d2), 32'd5);
        chk("done0_pulses", 32'(nd0), 32'd1);
        chk("q0_empty_a", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q2_empty", 32'(q2.size()), 32'd0);
        chk("ovf0_clear", 32'(s0_ovf), 32'd0);
        chk("ovf1_sticky", 32'(s1_ovf), 32'd1);
        chk("ovf2_clear", 32'(s2_ovf), 32'd0);
        chk("idle_addr", 32'(s0_addr), 32'd0);
        chk("idle_wdata", 32'(s0_wdata), 32'd0);
        chk("idle_addr2", 32'(s2_addr), 32'd32766);

        // Stall on term 5
        push_run0(16);
        s0_start = 1;
        tick;
        s0_start = 0;
        c = 0;
        while (!(s0_we && s0_addr == 15'd5) && c < 40) begin tick; c++; end
        chk("stall_reach", 32'(s0_addr), 32'd5);
        s0_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stall_we", 32'(s0_we), 32'd1);
            chk("stall_addr", 32'(s0_addr), 32'd5);
            chk("stall_data", 32'(s0_wdata), 32'd8);
        end
        s0_ready = 1;
        c = 0;
        while (!s0_done && c < 40) begin tick; c++; end
        chk("stall_done", 32'(s0_done), 32'd1);
        tick;
        chk("q0_empty_b", 32'(q0.size()), 32'd0);

        // Asynchronous reset during ADD at term 7
        push_run0(7);
        s0_start = 1;
        tick;
        s0_start = 0;
        c = 0;
        while (!(s0_we && s0_addr == 15'd7) && c < 40) begin tick; c++; end
        chk("clr_reach", 32'(s0_addr), 32'd7);
        clr_n = 0;
        #1;
        chk("clr_we", 32'(s0_we), 32'd0);
        chk("clr_busy", 32'(s0_busy), 32'd0);
        chk("clr_addr", 32'(s0_addr), 32'd0);
        chk("clr_wdata", 32'(s0_wdata), 32'd0);
        chk("clr_q_drained", 32'(q0.size()), 32'd0);
        repeat (2) tick;
        clr_n = 1;
        tick;
        chk("clr_idle_we", 32'(s0_we), 32'd0);
        push_run0(16);
        s0_start = 1;
        tick;
        s0_start = 0;
        chk("restart_addr", 32'(s0_addr), 32'd0);
        chk("restart_data", 32'(s0_wdata), 32'd1);
        c = 0;
        while (!s0_done && c < 40) begin tick; c++; end
        chk("restart_done", 32'(s0_done), 32'd1);
        tick;
        chk("q0_empty_c", 32'(q0.size()), 32'd0);

        // start held high across two runs
        push_run0(16);
        push_run0(16);
        s0_start = 1;
        c = 0;
        while (!s0_done && c < 40) begin tick; c++; end
        chk("held_lat", 32'(c), 32'd17);
        tick;
        chk("held_idle_busy", 32'(s0_busy), 32'd0);
        chk("held_idle_we", 32'(s0_we), 32'd0);
        tick;
        chk("held_seed_busy", 32'(s0_busy), 32'd1);
        chk("held_seed_addr", 32'(s0_addr), 32'd0);
        c = 0;
        while (!s0_done && c < 40) begin tick; c++; end
        chk("held_done2", 32'(s0_done), 32'd1);
        s0_start = 0;
        repeat (2) tick;
        chk("q0_empty_d", 32'(q0.size()), 32'd0);
        chk("held_end_busy", 32'(s0_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fib_seq_fsm
